ssd_scan_bcd: RTL



---
 rtl/ssd_scan_bcd.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/ssd_scan_bcd.sv
// Binary value -> BCD (sequential double-dabble) -> time-multiplexed seven-segment scan.
// Latency: load accepted at edge N, display/overflow update at edge N+BIN_WIDTH+1.
// Backpressure: none; a load while busy is held in a one-deep pending slot (newest wins).
// Optional: define SSD_LZ_BLANK_EN to darken leading-zero digits.
module ssd_scan_bcd #(
   parameter int NUM_DIGITS  = 4,
   parameter int BIN_WIDTH   = 16,
   parameter int REFRESH_DIV = 100000
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [BIN_WIDTH-1:0]  value,
   input  logic                  load,
   output logic                  busy,
   output logic                  overflow,
   output logic [NUM_DIGITS-1:0] anode,
   output logic [6:0]            ssdOut
);

   // Scratch carries two spare nibbles so no intermediate double-dabble result is cut off.
   localparam int SCR_W  = 4 * (NUM_DIGITS + 2);
   localparam int DISP_W = 4 * NUM_DIGITS;
   localparam int CNT_W  = $clog2(BIN_WIDTH + 1);
   localparam int REF_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   function automatic logic [63:0] pow10(input int n);
      logic [63:0] p;
      p = 64'd1;
      for (int k = 0; k < n; k++) p = p * 64'd10;
      return p;
   endfunction

   // First value that no longer fits in NUM_DIGITS decimal digits.
   localparam logic [63:0] OVF_LIMIT = pow10(NUM_DIGITS);

   function automatic logic [6:0] seg7(input logic [3:0] nib);
      case (nib)
         4'd0:    seg7 = 7'b0000001;
         4'd1:    seg7 = 7'b1001111;
         4'd2:    seg7 = 7'b0010010;
         4'd3:    seg7 = 7'b0000110;
         4'd4:    seg7 = 7'b1001100;
         4'd5:    seg7 = 7'b0100100;
         4'd6:    seg7 = 7'b0100000;
         4'd7:    seg7 = 7'b0001111;
         4'd8:    seg7 = 7'b0000000;
         4'd9:    seg7 = 7'b0000100;
         default: seg7 = 7'b1111111;
      endcase
   endfunction

   typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} stateT;

   stateT                state;
   logic [BIN_WIDTH-1:0] binReg;
   logic [SCR_W-1:0]     scratch;
   logic [CNT_W-1:0]     shiftCnt;
   logic                 ovfNext;
   logic                 pend;
   logic [BIN_WIDTH-1:0] pendVal;
   logic [DISP_W-1:0]    dispBcd;
   logic [REF_W-1:0]     refCnt;
   logic [IDX_W-1:0]     digitIdx;

   logic [BIN_WIDTH-1:0] startVal;
   logic                 startOvf;
   logic [SCR_W-1:0]     adj;
   logic [SCR_W-1:0]     scrNext;
   logic [BIN_WIDTH-1:0] binNext;
   logic [3:0]           curNib;
   logic                 curLit;
   logic [NUM_DIGITS-1:0] anodeNext;

   // Value that starts the next conversion: a same-cycle load beats the pending slot.
   always_comb begin
      startVal = load ? value : pendVal;
      startOvf = ({{(64 - BIN_WIDTH){1'b0}}, startVal} >= OVF_LIMIT);
   end

   // One double-dabble step: add 3 to nibbles >= 5, then shift {scratch, bin} left.
   always_comb begin
      adj = scratch;
      for (int k = 0; k < NUM_DIGITS + 2; k++) begin
         if (scratch[4*k +: 4] >= 4'd5) adj[4*k +: 4] = scratch[4*k +: 4] + 4'd3;
      end
      {scrNext, binNext} = {adj, binReg} << 1;
   end

   // Conversion FSM; the display register is only written in COMMIT.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         busy     <= 1'b0;
         overflow <= 1'b0;
         ovfNext  <= 1'b0;
         binReg   <= '0;
         scratch  <= '0;
         shiftCnt <= '0;
         pend     <= 1'b0;
         pendVal  <= '0;
         dispBcd  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (load) begin
                  binReg   <= value;
                  scratch  <= '0;
                  ovfNext  <= startOvf;
                  shiftCnt <= '0;
                  busy     <= 1'b1;
                  state    <= SHIFT;
               end
            end
            SHIFT: begin
               scratch  <= scrNext;
               binReg   <= binNext;
               shiftCnt <= shiftCnt + 1'b1;
               if (shiftCnt == CNT_W'(BIN_WIDTH - 1)) state <= COMMIT;
               if (load) begin
                  pend    <= 1'b1;
                  pendVal <= value;
               end
            end
            COMMIT: begin
               dispBcd  <= scratch[DISP_W-1:0];
               overflow <= ovfNext;
               if (pend || load) begin
                  binReg   <= startVal;
                  scratch  <= '0;
                  ovfNext  <= startOvf;
                  shiftCnt <= '0;
                  pend     <= 1'b0;
                  state    <= SHIFT;
               end else begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Refresh counter and digit index; the index steps each time the counter wraps.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         refCnt   <= '0;
         digitIdx <= '0;
      end else if (refCnt == REF_W'(REFRESH_DIV - 1)) begin
         refCnt   <= '0;
         digitIdx <= (digitIdx == IDX_W'(NUM_DIGITS - 1)) ? '0 : digitIdx + 1'b1;
      end else begin
         refCnt <= refCnt + 1'b1;
      end
   end

`ifdef SSD_LZ_BLANK_EN
   logic seenNz;
`endif

   // Select the current digit and decide whether its slot is lit.
   always_comb begin
      curNib    = '0;
      curLit    = 1'b0;
      anodeNext = '1;
`ifdef SSD_LZ_BLANK_EN
      seenNz    = 1'b0;
`endif
      for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
`ifdef SSD_LZ_BLANK_EN
         seenNz = seenNz | (dispBcd[4*k +: 4] != 4'd0);
`endif
         if (IDX_W'(k) == digitIdx) begin
            curNib = dispBcd[4*k +: 4];
`ifdef SSD_LZ_BLANK_EN
            curLit = overflow | seenNz | (k == 0);
`else
            curLit = 1'b1;
`endif
            anodeNext[k] = ~curLit;
         end
      end
   end

   // Registered pin drivers: one cycle behind the digit index.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         anode  <= '1;
         ssdOut <= 7'b1111111;
      end else begin
         anode <= anodeNext;
         if (!curLit)       ssdOut <= 7'b1111111;
         else if (overflow) ssdOut <= 7'b1111110;
         else               ssdOut <= seg7(curNib);
      end
   end

endmodule
